// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding and parameter legality for the input debouncer
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    ARM_HI    = 2'b01,
    STABLE_HI = 2'b11,
    ARM_LO    = 2'b10
  } db_state_e;

  localparam int MIN_SYNC_STAGES     = 2;
  localparam int MIN_DEBOUNCE_CYCLES = 2;

  function automatic bit params_legal(input int sync_stages, input int debounce_cycles);
    return (sync_stages >= MIN_SYNC_STAGES) && (debounce_cycles >= MIN_DEBOUNCE_CYCLES);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one channel: synchroniser, stability counter, debounce FSM, edge pulses
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (!params_legal(SYNC_STAGES, DEBOUNCE_CYCLES)) begin : g_bad_params
    $error("debounce_channel: SYNC_STAGES and DEBOUNCE_CYCLES must both be >= 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CNT_W-1:0]       cnt;
  db_state_e              state;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Any disagreement with the armed direction drops back to the stable state,
  // so a single bounce restarts the whole count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= STABLE_LO;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        STABLE_LO: begin
          if (s) begin
            state <= ARM_HI;
            cnt   <= '0;
          end
        end
        ARM_HI: begin
          if (!s) begin
            state <= STABLE_LO;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= STABLE_HI;
            cnt   <= '0;
            level <= 1'b1;
            rise  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STABLE_HI: begin
          if (!s) begin
            state <= ARM_LO;
            cnt   <= '0;
          end
        end
        ARM_LO: begin
          if (s) begin
            state <= STABLE_HI;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= STABLE_LO;
            cnt   <= '0;
            level <= 1'b0;
            fall  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= STABLE_LO;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/and_gate_input_debouncer.sv
// rtl/and_gate_input_debouncer.sv - two independent debounced channels feeding the AND gate A/B inputs
module and_gate_input_debouncer
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_a,
  input  logic raw_b,
  output logic A,
  output logic B,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);

  debounce_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ch_a (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (raw_a),
    .level(A),
    .rise (a_rise),
    .fall (a_fall)
  );

  debounce_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ch_b (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (raw_b),
    .level(B),
    .rise (b_rise),
    .fall (b_fall)
  );

endmodule

// File: tb/tb_and_gate_input_debouncer.sv
// tb/tb_and_gate_input_debouncer.sv - directed self-checking bench for and_gate_input_debouncer
module tb_and_gate_input_debouncer;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LAT  = SYNC + DEB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic raw_a = 1'b0;
  logic raw_b = 1'b0;
  logic A, B, a_rise, a_fall, b_rise, b_fall;

  int tests = 0;
  int fails = 0;

  and_gate_input_debouncer #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_a (raw_a),
    .raw_b (raw_b),
    .A     (A),
    .B     (B),
    .a_rise(a_rise),
    .a_fall(a_fall),
    .b_rise(b_rise),
    .b_fall(b_fall)
  );

  always #5 clk = ~clk;

  // Reference: a level is accepted once the synchronised input has disagreed with it
  // for DEB+1 consecutive edges (one arming edge plus DEB counted edges).
  logic [SYNC-1:0] ms [2];
  int              run [2];
  logic            m_lvl [2];
  logic            m_rise [2];
  logic            m_fall [2];
  logic            raw_v [2];

  assign raw_v[0] = raw_a;
  assign raw_v[1] = raw_b;

  always @(posedge clk or negedge rst_n) begin
    for (int c = 0; c < 2; c++) begin
      if (!rst_n) begin
        ms[c]     <= '0;
        run[c]    <= 0;
        m_lvl[c]  <= 1'b0;
        m_rise[c] <= 1'b0;
        m_fall[c] <= 1'b0;
      end else begin
        ms[c]     <= {ms[c][SYNC-2:0], raw_v[c]};
        m_rise[c] <= 1'b0;
        m_fall[c] <= 1'b0;
        if (ms[c][SYNC-1] != m_lvl[c]) begin
          if (run[c] == DEB) begin
            m_lvl[c]  <= ms[c][SYNC-1];
            m_rise[c] <= ms[c][SYNC-1];
            m_fall[c] <= !ms[c][SYNC-1];
            run[c]    <= 0;
          end else begin
            run[c] <= run[c] + 1;
          end
        end else begin
          run[c] <= 0;
        end
      end
    end
  end

  logic prev_ar = 1'b0, prev_af = 1'b0, prev_br = 1'b0, prev_bf = 1'b0;

  always @(negedge clk) begin
    tests++;
    if ((A & B) !== (m_lvl[0] & m_lvl[1])) begin
      fails++;
      $display("FAIL sb_and: A&B=%b model=%b at %0t", A & B, m_lvl[0] & m_lvl[1], $time);
    end
    tests++;
    if ({a_rise, a_fall, b_rise, b_fall} !== {m_rise[0], m_fall[0], m_rise[1], m_fall[1]}) begin
      fails++;
      $display("FAIL sb_pulses: got=%b model=%b at %0t", {a_rise, a_fall, b_rise, b_fall},
               {m_rise[0], m_fall[0], m_rise[1], m_fall[1]}, $time);
    end
    tests++;
    if ((a_rise && a_fall) || (b_rise && b_fall) || (a_rise && prev_ar) || (a_fall && prev_af) ||
        (b_rise && prev_br) || (b_fall && prev_bf)) begin
      fails++;
      $display("FAIL sb_pulse_shape: pulses=%b prev=%b required no overlap and 1-cycle at %0t",
               {a_rise, a_fall, b_rise, b_fall}, {prev_ar, prev_af, prev_br, prev_bf}, $time);
    end
    prev_ar = a_rise;
    prev_af = a_fall;
    prev_br = b_rise;
    prev_bf = b_fall;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    raw_a = 1'b1;
    raw_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      tests++;
      if ({A, B, a_rise, a_fall, b_rise, b_fall} !== 6'b0) begin
        fails++;
        $display("FAIL reset_outputs: got=%b required=000000 cycle %0d", {A, B, a_rise, a_fall, b_rise, b_fall}, i);
      end
    end
    raw_a = 1'b0;
    raw_b = 1'b0;
    tick();
    rst_n = 1'b1;
    settle(LAT + 2);
  endtask

  task automatic test_clean_press();
    raw_a = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      tests++;
      if ({A, a_rise, B, b_rise, b_fall} !== {(e >= LAT), (e == LAT), 3'b000}) begin
        fails++;
        $display("FAIL clean_press: edge %0d A,a_rise,B,b_rise,b_fall=%b required=%b", e,
                 {A, a_rise, B, b_rise, b_fall}, {(e >= LAT), (e == LAT), 3'b000});
      end
    end
    raw_a = 1'b0;
    settle(LAT + 3);
    tests++;
    if (A !== 1'b0) begin
      fails++;
      $display("FAIL clean_release: A=%b required=0", A);
    end
  endtask

  task automatic test_bounce();
    logic [4:0] pat;
    int rises;
    pat = 5'b10101;
    rises = 0;
    for (int e = 0; e < 16; e++) begin
      raw_a = (e < 5) ? pat[4 - e] : 1'b1;
      tick();
      rises += int'(a_rise);
      tests++;
      if (A !== (e >= 4 + LAT)) begin
        fails++;
        $display("FAIL bounce_level: edge %0d A=%b required=%b", e, A, (e >= 4 + LAT));
      end
    end
    tests++;
    if (rises != 1) begin
      fails++;
      $display("FAIL bounce_rise_count: rises=%0d required=1", rises);
    end
    raw_a = 1'b0;
    settle(LAT + 3);
  endtask

  task automatic test_short_glitch();
    int bad;
    bad = 0;
    for (int e = 0; e < 14; e++) begin
      raw_b = (e < DEB - 1);
      tick();
      if (B || b_rise || b_fall) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL short_glitch: cycles with B/b_rise/b_fall high=%0d required=0", bad);
    end
  endtask

  task automatic test_simultaneous();
    raw_a = 1'b1;
    raw_b = 1'b1;
    settle(LAT + 3);
    tests++;
    if ({A, B} !== 2'b11) begin
      fails++;
      $display("FAIL simul_high: A,B=%b required=11", {A, B});
    end
    raw_a = 1'b0;
    raw_b = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick();
      tests++;
      if ({A, B, a_fall, b_fall} !== {(e < LAT), (e < LAT), (e == LAT), (e == LAT)}) begin
        fails++;
        $display("FAIL simul_fall: edge %0d A,B,a_fall,b_fall=%b required=%b", e, {A, B, a_fall, b_fall},
                 {(e < LAT), (e < LAT), (e == LAT), (e == LAT)});
      end
    end
  endtask

  task automatic test_reset_mid_arm();
    raw_b = 1'b1;
    settle(LAT + 3);
    raw_a = 1'b1;
    settle(SYNC + 3);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({A, B, a_rise, b_rise} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_async: A,B,a_rise,b_rise=%b required=0000", {A, B, a_rise, b_rise});
    end
    tick();
    rst_n = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      tests++;
      if ({A, a_rise, B, b_rise} !== {(e >= LAT), (e == LAT), (e >= LAT), (e == LAT)}) begin
        fails++;
        $display("FAIL reset_relatency: edge %0d A,a_rise,B,b_rise=%b required=%b", e, {A, a_rise, B, b_rise},
                 {(e >= LAT), (e == LAT), (e >= LAT), (e == LAT)});
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_short_glitch();
    test_simultaneous();
    test_reset_mid_arm();
    settle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
